// File: rtl/ext_mem_initiator.sv
// Request-side initiator for the external memory port: queues single-word requests and runs the
// level-based rd/wr request / ack handshake one at a time. Optional ISSUE timeout: EXT_MEM_TIMEOUT_EN.
module ext_mem_initiator #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 64,
   parameter int TAG_W          = 4,
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic                         req_write,
   input  logic [DATA_W-1:0]            req_wdata,
   input  logic [TAG_W-1:0]             req_tag,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_write,
   output logic [TAG_W-1:0]             rsp_tag,
   output logic                         rsp_error,
   output logic [ADDR_W-1:0]            ext_mem_addr,
   output logic                         ext_mem_rd_req,
   output logic                         ext_mem_wr_req,
   output logic [DATA_W-1:0]            ext_mem_wr_data,
   input  logic [DATA_W-1:0]            ext_mem_rd_data,
   input  logic                         ext_mem_ack,
   output logic                         busy,
   output logic [$clog2(QUEUE_DEPTH):0] q_count
);
   // state   | meaning
   // IDLE    | waiting for a queued request and an empty response slot
   // ISSUE   | request level held, waiting for ack (or timeout)
   // RELEASE | levels dropped, waiting for the responder to drop ack
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              write;
      logic [DATA_W-1:0] wdata;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   entry_t             fifo_mem [QUEUE_DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               push, pop, start, can_issue;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               rd_req_q, rd_req_d, wr_req_q, wr_req_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic               cur_write_q, cur_write_d;
   logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic               rsp_write_q, rsp_write_d;
   logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

`ifdef EXT_MEM_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               rsp_error_q, rsp_error_d;
`else
   logic               unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   assign req_ready = (count_q != CNT_W'(QUEUE_DEPTH));
   assign push      = req_valid && req_ready;
   assign head      = fifo_mem[rd_ptr_q];
   assign can_issue = (count_q != '0) && !rsp_valid_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rd_req_d    = rd_req_q;
      wr_req_d    = wr_req_q;
      wr_data_d   = wr_data_q;
      cur_write_d = cur_write_q;
      cur_tag_d   = cur_tag_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_write_d = rsp_write_q;
      rsp_tag_d   = rsp_tag_q;
      pop         = 1'b0;
      start       = 1'b0;
`ifdef EXT_MEM_TIMEOUT_EN
      tmo_d       = tmo_q;
      rsp_error_d = rsp_error_q;
`endif
      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
         rsp_rdata_d = '0;
         rsp_write_d = 1'b0;
         rsp_tag_d   = '0;
`ifdef EXT_MEM_TIMEOUT_EN
         rsp_error_d = 1'b0;
`endif
      end
      case (state_q)
         S_IDLE: start = can_issue;
         S_ISSUE: begin
            if (ext_mem_ack) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = cur_write_q ? '0 : ext_mem_rd_data;
               rsp_write_d = cur_write_q;
               rsp_tag_d   = cur_tag_q;
               rd_req_d    = 1'b0;
               wr_req_d    = 1'b0;
               state_d     = S_RELEASE;
`ifdef EXT_MEM_TIMEOUT_EN
               rsp_error_d = 1'b0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_write_d = cur_write_q;
               rsp_tag_d   = cur_tag_q;
               rsp_error_d = 1'b1;
               rd_req_d    = 1'b0;
               wr_req_d    = 1'b0;
               state_d     = S_RELEASE;
            end else begin
               tmo_d = tmo_q + 1'b1;
`endif
            end
         end
         // Issuing straight out of RELEASE keeps the sustained rate at one transaction per 4 cycles.
         S_RELEASE: begin
            if (!ext_mem_ack) begin
               state_d = S_IDLE;
               start   = can_issue;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (start) begin
         pop         = 1'b1;
         addr_d      = head.addr;
         wr_data_d   = head.write ? head.wdata : '0;
         rd_req_d    = !head.write;
         wr_req_d    = head.write;
         cur_write_d = head.write;
         cur_tag_d   = head.tag;
         state_d     = S_ISSUE;
`ifdef EXT_MEM_TIMEOUT_EN
         tmo_d       = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= '{req_addr, req_write, req_wdata, req_tag};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         addr_q      <= '0;
         rd_req_q    <= 1'b0;
         wr_req_q    <= 1'b0;
         wr_data_q   <= '0;
         cur_write_q <= 1'b0;
         cur_tag_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_write_q <= 1'b0;
         rsp_tag_q   <= '0;
`ifdef EXT_MEM_TIMEOUT_EN
         tmo_q       <= '0;
         rsp_error_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
         rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
         count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
         addr_q      <= addr_d;
         rd_req_q    <= rd_req_d;
         wr_req_q    <= wr_req_d;
         wr_data_q   <= wr_data_d;
         cur_write_q <= cur_write_d;
         cur_tag_q   <= cur_tag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_write_q <= rsp_write_d;
         rsp_tag_q   <= rsp_tag_d;
`ifdef EXT_MEM_TIMEOUT_EN
         tmo_q       <= tmo_d;
         rsp_error_q <= rsp_error_d;
`endif
      end
   end

   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_write       = rsp_write_q;
   assign rsp_tag         = rsp_tag_q;
`ifdef EXT_MEM_TIMEOUT_EN
   assign rsp_error       = rsp_error_q;
`else
   assign rsp_error       = 1'b0;
`endif
   assign ext_mem_addr    = addr_q;
   assign ext_mem_rd_req  = rd_req_q;
   assign ext_mem_wr_req  = wr_req_q;
   assign ext_mem_wr_data = wr_data_q;
   assign busy            = (state_q != S_IDLE) || (count_q != '0);
   assign q_count         = count_q;

endmodule

// File: tb/tb_ext_mem_initiator.sv
// Bench for ext_mem_initiator: directed latency/backpressure/stale-ack/reset cases plus a random
// phase, all scored against an in-order request/response model and a registered-ack responder.
module tb_ext_mem_initiator;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_tag;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
   logic [63:0] rsp_rdata;
   logic [3:0]  rsp_tag;
   logic [31:0] ext_mem_addr;
   logic        ext_mem_rd_req, ext_mem_wr_req, ext_mem_ack;
   logic [63:0] ext_mem_wr_data, ext_mem_rd_data;
   logic        busy;
   logic [2:0]  q_count;

   int total = 0;
   int bad   = 0;

   ext_mem_initiator #(.TIMEOUT_CYCLES(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_write(rsp_write), .rsp_tag(rsp_tag), .rsp_error(rsp_error),
      .ext_mem_addr(ext_mem_addr), .ext_mem_rd_req(ext_mem_rd_req),
      .ext_mem_wr_req(ext_mem_wr_req), .ext_mem_wr_data(ext_mem_wr_data),
      .ext_mem_rd_data(ext_mem_rd_data), .ext_mem_ack(ext_mem_ack),
      .busy(busy), .q_count(q_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Echo responder: read data is the zero-extended address, ack is a registered copy of the
   // request level, optionally held stale_hold extra cycles after the level drops.
   assign ext_mem_rd_data = {32'h0, ext_mem_addr};
   bit   ack_en = 1'b1;
   int   stale_hold = 0;
   int   hold_left = 0;
   logic lvl_s;
   initial ext_mem_ack = 1'b0;
   always @(posedge clk) begin
      lvl_s = ext_mem_rd_req | ext_mem_wr_req;
      #1;
      if (rst) begin
         ext_mem_ack = 1'b0;
         hold_left   = 0;
      end else if (lvl_s) begin
         ext_mem_ack = ack_en;
         hold_left   = stale_hold;
      end else if (hold_left > 0 && ext_mem_ack) begin
         hold_left--;
      end else begin
         ext_mem_ack = 1'b0;
      end
   end

   // Reference model: every accepted request is issued and answered exactly once, in order.
   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [63:0] wdata;
      logic [3:0]  tag;
   } req_t;
   req_t        iss_q[$];
   req_t        exp_q[$];
   int          issue_cnt = 0, rsp_cnt = 0, rise_prev = 0, rise_last = 0;
   bit          noack_mode = 1'b0;
   logic        prev_lvl = 1'b0, prev_wr = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [63:0] prev_wdata = '0;

   always @(negedge clk) begin
      req_t r;
      logic lvl;
      if (rst) begin
         prev_lvl = 1'b0;
      end else begin
         if (req_valid && req_ready) begin
            r = '{req_addr, req_write, req_wdata, req_tag};
            iss_q.push_back(r);
            exp_q.push_back(r);
         end
         chk_val("one_level_at_a_time", ext_mem_rd_req & ext_mem_wr_req, 0);
         lvl = ext_mem_rd_req | ext_mem_wr_req;
         if (lvl && !prev_lvl) begin
            issue_cnt++;
            rise_prev = rise_last;
            rise_last = cyc;
            chk_val("ack_low_at_issue", ext_mem_ack, 0);
            chk_val("issue_has_request", iss_q.size() != 0, 1);
            if (iss_q.size() != 0) begin
               r = iss_q.pop_front();
               chk_val("issue_fields", {ext_mem_wr_req, ext_mem_addr, ext_mem_wr_data},
                       {r.write, r.addr, r.write ? r.wdata : 64'h0});
            end
         end else if (lvl) begin
            chk_val("issue_stable", {ext_mem_wr_req, ext_mem_addr, ext_mem_wr_data},
                    {prev_wr, prev_addr, prev_wdata});
         end
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            chk_val("rsp_has_request", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               chk_val("rsp_fields", {rsp_write, rsp_tag, rsp_error, rsp_rdata},
                       {r.write, r.tag, noack_mode,
                        (r.write || noack_mode) ? 64'h0 : {32'h0, r.addr}});
            end
         end
         prev_lvl   = lvl;
         prev_wr    = ext_mem_wr_req;
         prev_addr  = ext_mem_addr;
         prev_wdata = ext_mem_wr_data;
      end
   end

   task automatic push_req(input logic [31:0] a, input logic w, input logic [63:0] d, input logic [3:0] t);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = w;
      req_wdata = d;
      req_tag   = t;
      step();
      req_valid = 1'b0;
   endtask

   // Full timeline of one transaction from an idle block with rsp_ready held high.
   task automatic run_single(input logic [31:0] a, input logic w, input logic [63:0] d, input logic [3:0] t);
      chk_val("lat_c0_ready", req_ready, 1);
      push_req(a, w, d, t);
      chk_val("lat_c1_level", {ext_mem_rd_req, ext_mem_wr_req}, 0);
      chk_val("lat_c1_qcount", q_count, 1);
      step();
      chk_val("lat_c2_level", {ext_mem_rd_req, ext_mem_wr_req}, {!w, w});
      chk_val("lat_c2_addr", ext_mem_addr, a);
      chk_val("lat_c2_wdata", ext_mem_wr_data, w ? d : 64'h0);
      chk_val("lat_c2_busy", {busy, q_count}, 4'b1000);
      step();
      chk_val("lat_c3_ack", {ext_mem_ack, rsp_valid}, 2'b10);
      step();
      chk_val("lat_c4_rsp", {rsp_valid, rsp_write, rsp_tag, rsp_error}, {1'b1, w, t, 1'b0});
      chk_val("lat_c4_rdata", rsp_rdata, w ? 64'h0 : {32'h0, a});
      chk_val("lat_c4_level_ack", {ext_mem_rd_req, ext_mem_wr_req, ext_mem_ack}, 3'b001);
      step();
      chk_val("lat_c5", {rsp_valid, ext_mem_ack}, 0);
      step();
      chk_val("lat_c6_busy", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, base, base_iss;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
      req_tag = '0; rsp_ready = 1'b1;
      repeat (3) step();
      chk_val("rst_ready", req_ready, 1);
      chk_val("rst_ctl", {rsp_valid, rsp_write, rsp_tag, rsp_error, ext_mem_rd_req,
                          ext_mem_wr_req, busy, q_count}, 0);
      chk_val("rst_data", {rsp_rdata, ext_mem_wr_data}, 0);
      chk_val("rst_addr", ext_mem_addr, 0);
      rst = 1'b0;
      step();

      run_single(32'h0000_1000, 1'b0, 64'h0, 4'd3);
      run_single(32'h0000_0020, 1'b1, 64'hDEAD_BEEF, 4'd5);

      // Backpressure: slot held full, four more requests fill the FIFO behind it.
      rsp_ready = 1'b0;
      base_iss  = issue_cnt;
      for (int k = 0; k < 5; k++) begin
         chk_val("bp_ready", req_ready, 1);
         push_req(32'h100 + 32'(k * 8), k[0], {$urandom, $urandom}, 4'(k));
      end
      chk_val("bp_full_ready", req_ready, 0);
      chk_val("bp_full_qcount", q_count, 4);
      repeat (10) step();
      chk_val("bp_single_issue", issue_cnt - base_iss, 1);
      chk_val("bp_slot_held", rsp_valid, 1);
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (!rsp_valid && n < 30) begin step(); n++; end
         chk_val("bp_rsp_seen", rsp_valid, 1);
         chk_val("bp_tag_order", rsp_tag, k);
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end
      rsp_ready = 1'b1;
      repeat (3) step();

      // Stale ack: responder keeps ack high 3 cycles after the level drops.
      stale_hold = 3;
      base       = rsp_cnt;
      base_iss   = issue_cnt;
      push_req(32'h300, 1'b0, 64'h0, 4'd6);
      push_req(32'h308, 1'b0, 64'h0, 4'd7);
      n = 0;
      while (issue_cnt - base_iss < 2 && n < 40) begin step(); n++; end
      chk_val("stale_two_issues", issue_cnt - base_iss, 2);
      chk_val("stale_issue_gap", rise_last - rise_prev, 7);
      repeat (20) step();
      chk_val("stale_rsp_count", rsp_cnt - base, 2);
      stale_hold = 0;

`ifdef EXT_MEM_TIMEOUT_EN
      ack_en     = 1'b0;
      noack_mode = 1'b1;
      push_req(32'h400, 1'b0, 64'h0, 4'd8);
      push_req(32'h408, 1'b0, 64'h0, 4'd9);
      n = 0;
      while (!rsp_valid && n < 40) begin step(); n++; end
      chk_val("tmo_rsp", {rsp_valid, rsp_error, rsp_tag}, {2'b11, 4'd8});
      chk_val("tmo_rdata", rsp_rdata, 0);
      chk_val("tmo_latency", cyc - rise_last, 10);
      step();
      noack_mode = 1'b0;
      ack_en     = 1'b1;
      n = 0;
      while (!rsp_valid && n < 40) begin step(); n++; end
      chk_val("tmo_next", {rsp_valid, rsp_error, rsp_tag}, {2'b10, 4'd9});
      repeat (4) step();
      ack_en = 1'b0;
      push_req(32'h500, 1'b0, 64'h0, 4'd1);
      push_req(32'h508, 1'b0, 64'h0, 4'd2);
      push_req(32'h510, 1'b0, 64'h0, 4'd3);
      repeat (3) step();
`else
      ack_en = 1'b0;
      base   = rsp_cnt;
      push_req(32'h500, 1'b0, 64'h0, 4'd1);
      push_req(32'h508, 1'b0, 64'h0, 4'd2);
      push_req(32'h510, 1'b0, 64'h0, 4'd3);
      repeat (1000) step();
      chk_val("noack_no_rsp", {rsp_valid, 32'(rsp_cnt - base)}, 0);
`endif
      chk_val("pre_rst_state", {ext_mem_rd_req, q_count}, {1'b1, 3'd2});

      // Reset mid-ISSUE: outputs must drop without waiting for a clock edge.
      #1;
      rst = 1'b1;
      #1;
      chk_val("rst_async_level", {ext_mem_rd_req, ext_mem_wr_req}, 0);
      chk_val("rst_async_state", {q_count, busy, rsp_valid}, 0);
      iss_q.delete();
      exp_q.delete();
      noack_mode = 1'b0;
      base = rsp_cnt;
      step();
      step();
      rst    = 1'b0;
      ack_en = 1'b1;
      repeat (5) step();
      chk_val("post_rst_quiet", {rsp_valid, busy, 32'(rsp_cnt - base)}, 0);
      run_single(32'h0000_5550, 1'b0, 64'h0, 4'hA);

      // Random traffic with random consumer backpressure and stale-ack lengths.
      for (int i = 0; i < 400; i++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_addr  = $urandom;
         req_write = 1'($urandom_range(0, 1));
         req_wdata = {$urandom, $urandom};
         req_tag   = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (i % 50 == 0) stale_hold = $urandom_range(0, 2);
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin step(); n++; end
      chk_val("drain_empty", exp_q.size(), 0);
      chk_val("drain_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ext_mem_initiator.md
# ext_mem_initiator

Request-side master for the chip's simplified external memory port: the off-chip miss path of the on-chip memory network pushes single-word read/write requests into this block. The block queues them, drives the level-based `ext_mem_*` request/acknowledge handshake one transaction at a time, and returns tagged responses. It sits between the network's external channel and the processor's external memory responder. It is the initiator for that responder.

## Interface
Parameters:
- `ADDR_W`, 32: request address width.
- `DATA_W`, 64: data word width, equal to `reg_data_t`.
- `TAG_W`, 4: request tag width.
- `QUEUE_DEPTH`, 4: request FIFO entries, power of two, ≥2.
- `TIMEOUT_CYCLES`, 255: ISSUE cycles without ack before an error response. Only used when `EXT_MEM_TIMEOUT_EN` is defined.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input 1: request offered.
- `req_ready` output 1: FIFO not full.
- `req_addr` input ADDR_W: byte address.
- `req_write` input 1: 1 = write, 0 = read.
- `req_wdata` input DATA_W: write data.
- `req_tag` input TAG_W: echoed in the response.
- `rsp_valid` output 1: response held.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_rdata` output DATA_W: read data; 0 for writes and errors.
- `rsp_write` output 1: echo of `req_write`.
- `rsp_tag` output TAG_W: echo of `req_tag`.
- `rsp_error` output 1: transaction timed out.
- `ext_mem_addr` output ADDR_W: registered address.
- `ext_mem_rd_req` output 1: read request level.
- `ext_mem_wr_req` output 1: write request level.
- `ext_mem_wr_data` output DATA_W: registered write data.
- `ext_mem_rd_data` input DATA_W: responder read data.
- `ext_mem_ack` input 1: responder acknowledge level.
- `busy` output 1: FSM not IDLE or FIFO not empty.
- `q_count` output $clog2(QUEUE_DEPTH)+1: FIFO occupancy.

## Operation
- **Accept:** a request is accepted when `req_valid && req_ready`; `{addr, write, wdata, tag}` is written into the FIFO. Push and pop in the same cycle are legal. `req_ready = (q_count != QUEUE_DEPTH)`.
- **FSM states:** IDLE, ISSUE, RELEASE.
- **IDLE:**
  - If the FIFO is not empty and the response slot is empty, pop the FIFO.
  - Register `ext_mem_addr`, and `ext_mem_wr_data` (0 for reads).
  - Set exactly one of `ext_mem_rd_req` / `ext_mem_wr_req` per `write`.
  - Clear the timeout counter and go to ISSUE.
- **ISSUE:**
  - Request level and addr/data are held stable.
  - On `ext_mem_ack == 1`: capture `ext_mem_rd_data` (reads) into `rsp_rdata`, set `rsp_valid`, `rsp_error = 0`, drop both request levels, and go to RELEASE.
- **RELEASE:**
  - Request levels stay 0.
  - Any `ext_mem_ack` seen here is stale and is ignored.
  - When `ext_mem_ack == 0`, go to IDLE.
- **Response slot:** the slot holds its value until `rsp_valid && rsp_ready`, then clears. IDLE does not pop while the slot is full. There is at most one transaction in flight, and responses come out in request order.
- `ext_mem_rd_req` and `ext_mem_wr_req` are never high together.

## Timing
- **Reset values:** all outputs are 0 except `req_ready` = 1. The FIFO is emptied, the FSM goes to IDLE, and the counters are cleared.
- **Reset mid-transaction:** the in-flight transaction and queued requests are discarded, no response is produced, and the request levels drop asynchronously.
- **Latency against the registered-ack responder, with an empty FIFO and `rsp_ready = 1`:**
  - Cycle 0: request accepted.
  - Cycle 2: request level high.
  - Cycle 3: ack seen.
  - Cycle 4: `rsp_valid` high and request level low.
  - Cycle 4: stale ack is still high.
  - Cycle 5: ack low, FSM goes to IDLE.
  - Cycle 6: next request level high.
- **Sustained rate:** one transaction per 4 cycles.
- `busy` and `q_count` are registered-state derived. `q_count` updates the cycle after a push or pop.

## Configuration
- **`EXT_MEM_TIMEOUT_EN` defined:**
  - An 8-bit-or-wider counter increments each ISSUE cycle.
  - When it reaches `TIMEOUT_CYCLES` with no ack: set `rsp_valid`, `rsp_error = 1`, `rsp_rdata = 0`, drop the request level, and go to RELEASE. RELEASE then waits for ack low as normal.
- **Undefined:**
  - No counter is built.
  - ISSUE waits indefinitely.
  - `rsp_error` is tied to 0.

## Test plan
- **Single read:** read of addr 0x0000_1000, tag 3, with the echo responder (`rd_data` = addr) → cycle 4: `rsp_valid`=1, `rsp_rdata`=0x1000, `rsp_tag`=3, `rsp_write`=0, `rsp_error`=0. Both request levels are 0 from cycle 4.
- **Write:** addr 0x20, data 0xDEAD_BEEF, tag 5 → `ext_mem_wr_req`=1 with `wr_data`=0xDEAD_BEEF stable until ack. Response has `rsp_write`=1, `rsp_rdata`=0, tag 5. `ext_mem_rd_req` stays 0 throughout.
- **Full queue and backpressure:**
  - Stimulus: push 5 back-to-back requests with `rsp_ready`=0.
  - Required: `req_ready` drops after the FIFO fills with 4 queued entries behind the first in-flight transaction (which was popped into the response slot).
  - Required: no second issue until `rsp_ready` pulses.
  - Required: responses are drained in tag order 0..4.
- **Stale ack:** a responder that holds ack 3 cycles after the request drops → no extra response is produced, and the next issue waits until ack is 0.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=10):** a responder that never acks → after 10 ISSUE cycles, `rsp_error`=1 and `rsp_rdata`=0, and the next queued request proceeds. With the macro undefined, the bench sees no response after 1000 cycles.
- **Reset mid-ISSUE:** assert `rst` while `ext_mem_rd_req`=1 with 2 queued → outputs drop immediately, `q_count`=0, and no `rsp_valid` after release. A fresh request then completes with the normal 4-cycle latency.
